serial_bcd_alu: RTL and testbench

Parametrised bit-serial adder/subtractor for the HP-35 datapath, generalising the single-bit full adder used in the serial arithmetic paths. It consumes two LSB-first serial words of `NumDigits` digits, keeps carry/borrow in a flip-flop between bit times, and applies per-digit decimal correction in BCD mode. The corrected result is re-serialised one digit late. It targets Serial Adder 84 (A&R circuit 20) and Serial Adder/Subtractor 64 (C&T circuit 16).

---
 rtl/serial_bcd_alu.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_bcd_alu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bcd_alu.sv
// serial_bcd_alu
// Bit-serial adder/subtractor for the HP-35 datapath. Two LSB-first serial
// words of NumDigits digits (DigitBits bits each, WordBits = NumDigits *
// DigitBits in total) are combined one bit per clock. The carry or borrow is
// kept in a flop between bit times. In BCD mode each digit gets a decimal
// correction on its last bit. The corrected digit is then shifted out one
// digit time later.
//
// Ports:
//   clk       : single clock, rising edge.
//   rst       : synchronous active-high reset.
//   start     : bit time 0 of a word; x/y/sub/bcd are valid in this cycle.
//   x, y      : serial operand bits, LSB first (x - y when subtracting).
//   sub       : 1 = subtract, sampled with start.
//   bcd       : 1 = per-digit decimal correction, sampled with start.
//   sum       : serial result bit, LSB first, DigitBits cycles behind the input.
//   sum_valid : sum carries a result bit.
//   co        : final carry/borrow of the last completed word.
//   done      : one-cycle pulse when co updates.
//   busy      : the input side is in the middle of a word.
module serial_bcd_alu #(
  parameter int NumDigits = 14,
  parameter int DigitBits = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic x,
  input  logic y,
  input  logic sub,
  input  logic bcd,
  output logic sum,
  output logic sum_valid,
  output logic co,
  output logic done,
  output logic busy
);

  localparam int BitCntW = (DigitBits > 1) ? $clog2(DigitBits) : 1;
  localparam int DigCntW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [BitCntW-1:0]   LastBit = BitCntW'(DigitBits - 1);
  localparam logic [DigCntW-1:0]   LastDig = DigCntW'(NumDigits - 1);
  localparam logic [DigitBits-1:0] Six     = DigitBits'(4'd6);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DigCntW-1:0]   dig_cnt_q, dig_cnt_d;
  logic                 carry_q, carry_d;
  logic                 sub_q, sub_d;
  logic                 bcd_q, bcd_d;
  logic [DigitBits-1:0] acc_q, acc_d;
  logic [DigitBits-1:0] out_sr_q, out_sr_d;
  logic [BitCntW-1:0]   out_cnt_q, out_cnt_d;
  logic                 sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic                 co_q, co_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Effective per-bit context. A start cycle is bit 0 of a fresh word, so
  // it ignores the counters, the carry flop and the latched mode.
  logic                 active;
  logic [BitCntW-1:0]   eff_bit;
  logic [DigCntW-1:0]   eff_dig;
  logic                 c_in;
  logic                 op_sub;
  logic                 op_bcd;
  logic                 s_bit;
  logic                 c_raw;
  logic [DigitBits-1:0] raw_digit;
  logic [DigitBits-1:0] corr_digit;
  logic                 corr_carry;
  logic                 digit_end;
  logic                 word_end;

  // Next-state logic: serial full adder/subtractor, digit correction,
  // counters and output shifter.
  always_comb begin
    active = start | (state_q == StRun);

    if (start) begin
      eff_bit = '0;
      eff_dig = '0;
      c_in    = 1'b0;
      op_sub  = sub;
      op_bcd  = bcd;
    end else begin
      eff_bit = bit_cnt_q;
      eff_dig = dig_cnt_q;
      c_in    = carry_q;
      op_sub  = sub_q;
      op_bcd  = bcd_q;
    end

    s_bit = x ^ y ^ c_in;
    if (op_sub) begin
      c_raw = (~x & y) | (~(x ^ y) & c_in);
    end else begin
      c_raw = (x & y) | (x & c_in) | (y & c_in);
    end

    // The new bit enters at the MSB, so after DigitBits shifts the
    // digit sits LSB-aligned in the accumulator.
    raw_digit = (acc_q >> 1'b1) | (DigitBits'(s_bit) << (DigitBits - 1));
    digit_end = active && (eff_bit == LastBit);
    word_end  = digit_end && (eff_dig == LastDig);

    // Decimal correction. It is only meaningful on the last bit of a digit.
    if (op_bcd) begin
      if (op_sub) begin
        if (c_raw) begin
          corr_digit = raw_digit - Six;
          corr_carry = 1'b1;
        end else begin
          corr_digit = raw_digit;
          corr_carry = 1'b0;
        end
      end else if (c_raw || (32'(raw_digit) > 32'd9)) begin
        corr_digit = raw_digit + Six;
        corr_carry = 1'b1;
      end else begin
        corr_digit = raw_digit;
        corr_carry = c_raw;
      end
    end else begin
      corr_digit = raw_digit;
      corr_carry = c_raw;
    end

    // Input side defaults: hold.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dig_cnt_d = dig_cnt_q;
    carry_d   = carry_q;
    sub_d     = sub_q;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    co_d      = co_q;
    done_d    = 1'b0;

    if (active) begin
      sub_d = op_sub;
      bcd_d = op_bcd;
      if (digit_end) begin
        acc_d     = '0;
        bit_cnt_d = '0;
        if (word_end) begin
          // The carry never crosses into the next word.
          state_d   = StIdle;
          dig_cnt_d = '0;
          carry_d   = 1'b0;
          co_d      = corr_carry;
          done_d    = 1'b1;
        end else begin
          state_d   = StRun;
          dig_cnt_d = eff_dig + 1'b1;
          carry_d   = corr_carry;
        end
      end else begin
        state_d   = StRun;
        acc_d     = raw_digit;
        bit_cnt_d = eff_bit + 1'b1;
        dig_cnt_d = eff_dig;
        carry_d   = c_raw;
      end
    end else begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      dig_cnt_d = dig_cnt_q;
      carry_d   = carry_q;
    end

    busy_d = (state_d == StRun);

    // Output side: a finished digit goes straight to sum. Its remaining bits
    // then drain from the shifter. This runs independently of the input side,
    // so an aborted word still flushes digits that were already loaded.
    if (digit_end) begin
      sum_d       = corr_digit[0];
      out_sr_d    = corr_digit >> 1'b1;
      out_cnt_d   = LastBit;
      sum_valid_d = 1'b1;
    end else if (out_cnt_q != '0) begin
      sum_d       = out_sr_q[0];
      out_sr_d    = out_sr_q >> 1'b1;
      out_cnt_d   = out_cnt_q - 1'b1;
      sum_valid_d = 1'b1;
    end else begin
      sum_d       = 1'b0;
      out_sr_d    = '0;
      out_cnt_d   = '0;
      sum_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      dig_cnt_q   <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      bcd_q       <= 1'b0;
      acc_q       <= '0;
      out_sr_q    <= '0;
      out_cnt_q   <= '0;
      sum_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      co_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dig_cnt_q   <= dig_cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      bcd_q       <= bcd_d;
      acc_q       <= acc_d;
      out_sr_q    <= out_sr_d;
      out_cnt_q   <= out_cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      co_q        <= co_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign co        = co_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_bcd_alu.sv
// Testbench for serial_bcd_alu. There are two instances: a 14-digit one and a
// 2-digit one. Each word's result comes from whole-number arithmetic, either
// modulo 10^n or modulo 2^(4n). The result is scheduled per cycle and checked
// every cycle by one compare process.
module tb_serial_bcd_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, x, y, sub, bcd, start14, start2;
  logic sum14, sv14, co14, done14, busy14;
  logic sum2, sv2, co2, done2, busy2;

  serial_bcd_alu #(.NumDigits(14), .DigitBits(4)) dut14 (
    .clk(clk), .rst(rst), .start(start14), .x(x), .y(y), .sub(sub), .bcd(bcd),
    .sum(sum14), .sum_valid(sv14), .co(co14), .done(done14), .busy(busy14));

  serial_bcd_alu #(.NumDigits(2), .DigitBits(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x(x), .y(y), .sub(sub), .bcd(bcd),
    .sum(sum2), .sum_valid(sv2), .co(co2), .done(done2), .busy(busy2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_on = 1'b0;

  // Expectations keyed by instance*1000000 + cycle.
  bit e_sum[int];
  bit e_done[int];
  bit e_co[int];
  bit e_busy[int];
  bit cur_co[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [55:0] enc(input longint v, input int nd, input bit is_bcd);
    logic [55:0] r = '0;
    longint w = v;
    if (is_bcd) begin
      for (int d = 0; d < nd; d++) begin
        r[4*d +: 4] = 4'(w % 10);
        w = w / 10;
      end
    end else begin
      for (int i = 0; i < 4*nd; i++) r[i] = w[i];
    end
    return r;
  endfunction

  task automatic model(input int nd, input bit is_sub, input bit is_bcd,
                       input longint xv, input longint yv,
                       output logic [55:0] er, output bit c);
    longint m, res;
    m = is_bcd ? pow10(nd) : (longint'(1) << (4*nd));
    if (is_sub) begin
      res = xv - yv;
      c = (res < 0);
      if (c) res = res + m;
    end else begin
      res = xv + yv;
      c = (res >= m);
      if (c) res = res - m;
    end
    er = enc(res, nd, is_bcd);
  endtask

  // Drives nbits bits of a word to instance k (0: 14 digits, 1: 2 digits).
  // It schedules only the digits that finish, and schedules done only for a
  // complete word.
  task automatic run_word(input int k, input bit is_sub, input bit is_bcd,
                          input longint xv, input longint yv, input int nbits);
    int nd, wb, t0, base;
    logic [55:0] ex, ey, er;
    bit c;
    nd = (k == 0) ? 14 : 2;
    wb = 4 * nd;
    base = k * 1000000;
    model(nd, is_sub, is_bcd, xv, yv, er, c);
    ex = enc(xv, nd, is_bcd);
    ey = enc(yv, nd, is_bcd);
    t0 = cyc;
    for (int i = 0; i < (nbits / 4) * 4; i++) e_sum[base + t0 + i + 4] = er[i];
    if (nbits == wb) begin
      e_done[base + t0 + wb] = 1'b1;
      e_co[base + t0 + wb] = c;
    end
    for (int i = 1; i < nbits; i++) e_busy[base + t0 + i] = 1'b1;
    if (nbits < wb) e_busy[base + t0 + nbits] = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (k == 0) start14 = (i == 0); else start2 = (i == 0);
      x = ex[i];
      y = ey[i];
      if (i == 0) begin
        sub = is_sub;
        bcd = is_bcd;
      end else begin
        sub = 1'($urandom);
        bcd = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start14 = 1'b0;
    start2 = 1'b0;
    x = 1'($urandom);
    y = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      x = 1'($urandom);
      y = 1'($urandom);
      sub = 1'($urandom);
      bcd = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic rst_mid();
    int r, key;
    r = cyc;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = r + 1; c < r + 200; c++) begin
        key = k * 1000000 + c;
        if (e_sum.exists(key)) e_sum.delete(key);
        if (e_done.exists(key)) e_done.delete(key);
        if (e_co.exists(key)) e_co.delete(key);
        if (e_busy.exists(key)) e_busy.delete(key);
      end
      e_co[k * 1000000 + r + 1] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Per-cycle compare of both instances against the schedule.
  initial begin
    logic a_sum, a_sv, a_co, a_done, a_busy;
    string p;
    int key;
    forever begin
      @(negedge clk);
      if (check_on) begin
        for (int k = 0; k < 2; k++) begin
          key = k * 1000000 + cyc;
          if (k == 0) begin
            {a_sum, a_sv, a_co, a_done, a_busy} = {sum14, sv14, co14, done14, busy14};
            p = "dut14";
          end else begin
            {a_sum, a_sv, a_co, a_done, a_busy} = {sum2, sv2, co2, done2, busy2};
            p = "dut2";
          end
          chk({p, " sum_valid"}, a_sv, e_sum.exists(key));
          if (e_sum.exists(key)) chk({p, " sum"}, a_sum, e_sum[key]);
          if (e_co.exists(key)) cur_co[k] = e_co[key];
          chk({p, " co"}, a_co, cur_co[k]);
          chk({p, " done"}, a_done, e_done.exists(key));
          chk({p, " busy"}, a_busy, e_busy.exists(key));
        end
      end
    end
  end

  initial begin
    logic [55:0] er;
    bit c;
    rst = 1'b1; start14 = 1'b0; start2 = 1'b0;
    x = 1'b0; y = 1'b0; sub = 1'b0; bcd = 1'b0;
    cur_co[0] = 1'b0; cur_co[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset sum14", sum14, 1'b0);   chk("reset sum_valid14", sv14, 1'b0);
    chk("reset co14", co14, 1'b0);     chk("reset done14", done14, 1'b0);
    chk("reset busy14", busy14, 1'b0);
    chk("reset sum2", sum2, 1'b0);     chk("reset sum_valid2", sv2, 1'b0);
    chk("reset co2", co2, 1'b0);       chk("reset done2", done2, 1'b0);
    chk("reset busy2", busy2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_on = 1'b1;
    idle(2);

    // Hand-computed results that pin the model.
    model(14, 1'b0, 1'b1, 999, 1, er, c);
    chk("pin bcd add r", er, 56'h00000000001000); chk("pin bcd add c", c, 1'b0);
    model(14, 1'b0, 1'b1, 64'd99999999999999, 1, er, c);
    chk("pin bcd ovf r", er, 56'h0); chk("pin bcd ovf c", c, 1'b1);
    model(14, 1'b1, 1'b1, 100, 1, er, c);
    chk("pin bcd sub r", er, 56'h99); chk("pin bcd sub c", c, 1'b0);
    model(14, 1'b1, 1'b1, 1, 2, er, c);
    chk("pin bcd neg r", er, 56'h99999999999999); chk("pin bcd neg c", c, 1'b1);
    model(2, 1'b0, 1'b0, 15, 1, er, c);
    chk("pin bin add r", er, 56'h10); chk("pin bin add c", c, 1'b0);
    model(2, 1'b1, 1'b0, 0, 1, er, c);
    chk("pin bin sub r", er, 56'hFF); chk("pin bin sub c", c, 1'b1);

    // Single words on the 14-digit instance.
    run_word(0, 1'b0, 1'b1, 999, 1, 56);                    idle(6);
    run_word(0, 1'b0, 1'b1, 64'd99999999999999, 1, 56);     idle(6);
    // Back-to-back words with changing op and mode.
    run_word(0, 1'b1, 1'b1, 100, 1, 56);
    run_word(0, 1'b1, 1'b1, 1, 2, 56);
    run_word(0, 1'b0, 1'b0, 5, 3, 56);
    run_word(0, 1'b0, 1'b1, 4567, 5433, 56);                idle(6);
    // Two-digit instance: binary and BCD.
    run_word(1, 1'b0, 1'b0, 15, 1, 8);
    run_word(1, 1'b1, 1'b0, 0, 1, 8);
    run_word(1, 1'b0, 1'b1, 45, 67, 8);
    run_word(1, 1'b1, 1'b1, 37, 37, 8);                     idle(6);
    // Abort: restart 10 bits into a word.
    run_word(0, 1'b0, 1'b1, 64'd99999999999999, 1, 56);
    run_word(0, 1'b0, 1'b1, 123, 456, 10);
    run_word(0, 1'b0, 1'b1, 500, 500, 56);                  idle(6);
    // Reset 20 bits into a word.
    run_word(0, 1'b1, 1'b1, 5000, 1, 20);
    rst_mid();
    idle(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
